// File: rtl/bpb_pkg.sv
// Shared definitions for the fetch PC controller and local branch predictor interface.
package bpb_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'hBFC0_0000;
  localparam logic [31:0] FALL_OFFSET_DEF = 32'd4;
  localparam int          BPB_T           = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        prd;
    logic [31:0] prd_addr;
  } fd_pred_t;

  // Word-aligned PC; callers keep the low TAG_WIDTH bits as the predictor tag.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && !(&count_q)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC selection plus the F->D prediction register and D-stage misprediction check.
module fetch_pc_ctrl
  import bpb_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          TAG_WIDTH   = BPB_T,
  parameter logic [31:0] FALL_OFFSET = FALL_OFFSET_DEF,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          flush_addr,
  input  logic                 prd,
  input  logic [31:0]          prd_addr,
  input  logic                 isBranchD,
  input  logic                 real_taken,
  input  logic [31:0]          real_addr,
  output logic [31:0]          pcF,
  output logic [TAG_WIDTH-1:0] PCF,
  output logic [TAG_WIDTH-1:0] PCD,
  output logic [31:0]          pcD,
  output logic                 validD,
  output logic                 MistakeD,
  output logic [31:0]          redirect_addr,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  logic [31:0] pc_q, pc_d;
  fd_pred_t    fd_q, fd_d;
  logic        mistake;
  logic [31:0] redirect;
  logic [31:0] tag_f_full, tag_d_full;

  // A taken prediction on a non-branch is a stale or aliased predictor entry.
  assign mistake = fd_q.valid &
                   ((isBranchD & ((fd_q.prd != real_taken) |
                                  (real_taken & (fd_q.prd_addr != real_addr)))) |
                    (~isBranchD & fd_q.prd));

  assign redirect = (isBranchD & real_taken) ? real_addr : (fd_q.pc + FALL_OFFSET);

  always_comb begin
    pc_d = pc_q;
    fd_d = fd_q;
    if (flush) begin
      pc_d       = flush_addr;
      fd_d.valid = 1'b0;
    end else if (!stall) begin
      if (mistake) begin
        pc_d       = redirect;
        fd_d.valid = 1'b0;
      end else begin
        pc_d          = prd ? prd_addr : (pc_q + 32'd4);
        fd_d.valid    = 1'b1;
        fd_d.pc       = pc_q;
        fd_d.prd      = prd;
        fd_d.prd_addr = prd_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      fd_q <= '0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (fd_q.valid & isBranchD),
    .hold  (stall | flush),
    .count (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mistake),
    .hold  (stall | flush),
    .count (mispredict_cnt)
  );

  assign tag_f_full    = pc_tag(pc_q);
  assign tag_d_full    = pc_tag(fd_q.pc);
  assign PCF           = tag_f_full[TAG_WIDTH-1:0];
  assign PCD           = tag_d_full[TAG_WIDTH-1:0];
  assign pcF           = pc_q;
  assign pcD           = fd_q.pc;
  assign validD        = fd_q.valid;
  assign MistakeD      = mistake;
  assign redirect_addr = redirect;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench: driver queues hand-computed expectations, negedge monitor compares.
module tb_fetch_pc_ctrl;

  localparam int CW = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0, flush = 1'b0, prd = 1'b0;
  logic          isBranchD = 1'b0, real_taken = 1'b0;
  logic [31:0]   flush_addr = '0, prd_addr = '0, real_addr = '0;
  logic [31:0]   pcF, pcD, redirect_addr;
  logic [TW-1:0] PCF, PCD;
  logic          validD, MistakeD;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  typedef struct {
    logic [31:0] pc_f;
    logic        vld;
    logic [31:0] pc_d;
    logic        mis;
    logic [31:0] red;
    int          bc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_addr(flush_addr),
    .prd(prd), .prd_addr(prd_addr), .isBranchD(isBranchD), .real_taken(real_taken),
    .real_addr(real_addr), .pcF(pcF), .PCF(PCF), .PCD(PCD), .pcD(pcD), .validD(validD),
    .MistakeD(MistakeD), .redirect_addr(redirect_addr), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  task automatic chk(input int n, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", n, name, act, req);
    end
  endtask

  task automatic vec(input bit rst, input bit st, input bit fl, input logic [31:0] fa,
                     input bit p, input logic [31:0] pa, input bit ib, input bit rt,
                     input logic [31:0] ra, input logic [31:0] e_pcf, input bit e_v,
                     input logic [31:0] e_pcd, input bit e_m, input logic [31:0] e_red,
                     input int e_bc, input int e_mc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; stall = st; flush = fl; flush_addr = fa; prd = p; prd_addr = pa;
    isBranchD = ib; real_taken = rt; real_addr = ra;
    e.pc_f = e_pcf; e.vld = e_v; e.pc_d = e_pcd; e.mis = e_m; e.red = e_red;
    e.bc = e_bc; e.mc = e_mc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(vec_no, "pcF", pcF, e.pc_f);
        chk(vec_no, "PCF", {24'd0, PCF}, {24'd0, e.pc_f[TW+1:2]});
        chk(vec_no, "validD", {31'd0, validD}, {31'd0, e.vld});
        chk(vec_no, "pcD", pcD, e.pc_d);
        chk(vec_no, "PCD", {24'd0, PCD}, {24'd0, e.pc_d[TW+1:2]});
        chk(vec_no, "MistakeD", {31'd0, MistakeD}, {31'd0, e.mis});
        chk(vec_no, "redirect_addr", redirect_addr, e.red);
        chk(vec_no, "branch_cnt", {28'd0, branch_cnt}, e.bc);
        chk(vec_no, "mispredict_cnt", {28'd0, mispredict_cnt}, e.mc);
        $display("vec%0d pcF=%h validD=%0d pcD=%h MistakeD=%0d redir=%h bcnt=%0d mcnt=%0d",
                 vec_no, pcF, validD, pcD, MistakeD, redirect_addr, branch_cnt, mispredict_cnt);
        vec_no++;
      end
    end
  end

  initial begin : driver
    int drain;
    //   rst st fl fa            p  pa       ib rt ra       pcF           v  pcD           m  red           bc mc
    vec(1, 0, 0, 0,             0, 0,        0, 0, 0,       32'hBFC00000, 0, 32'h0,        0, 32'h4,        0, 0);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'hBFC00000, 0, 32'h0,        0, 32'h4,        0, 0);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'hBFC00004, 1, 32'hBFC00000, 0, 32'hBFC00004, 0, 0);
    vec(0, 0, 1, 32'h100,       0, 0,        0, 0, 0,       32'hBFC00008, 1, 32'hBFC00004, 0, 32'hBFC00008, 0, 0);
    // Predicted taken to 0x200, resolved taken to 0x200: no mistake.
    vec(0, 0, 0, 0,             1, 32'h200,  0, 0, 0,       32'h100,      0, 32'hBFC00004, 0, 32'hBFC00008, 0, 0);
    vec(0, 0, 0, 0,             0, 0,        1, 1, 32'h200, 32'h200,      1, 32'h100,      0, 32'h200,      0, 0);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h204,      1, 32'h200,      0, 32'h204,      1, 0);
    // Predicted taken to 0x200, resolved not taken: redirect to 0x104.
    vec(0, 0, 1, 32'h100,       0, 0,        0, 0, 0,       32'h208,      1, 32'h204,      0, 32'h208,      1, 0);
    vec(0, 0, 0, 0,             1, 32'h200,  0, 0, 0,       32'h100,      0, 32'h204,      0, 32'h208,      1, 0);
    vec(0, 0, 0, 0,             0, 0,        1, 0, 32'h104, 32'h200,      1, 32'h100,      1, 32'h104,      1, 0);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h104,      0, 32'h100,      0, 32'h104,      2, 1);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h108,      1, 32'h104,      0, 32'h108,      2, 1);
    // Taken prediction on a non-branch at 0x40, held by a 3-cycle stall.
    vec(0, 0, 1, 32'h40,        0, 0,        0, 0, 0,       32'h10C,      1, 32'h108,      0, 32'h10C,      2, 1);
    vec(0, 0, 0, 0,             1, 32'h80,   0, 0, 0,       32'h40,       0, 32'h108,      0, 32'h10C,      2, 1);
    vec(0, 1, 0, 0,             0, 0,        0, 0, 0,       32'h80,       1, 32'h40,       1, 32'h44,       2, 1);
    vec(0, 1, 0, 0,             0, 0,        0, 0, 0,       32'h80,       1, 32'h40,       1, 32'h44,       2, 1);
    vec(0, 1, 0, 0,             0, 0,        0, 0, 0,       32'h80,       1, 32'h40,       1, 32'h44,       2, 1);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h80,       1, 32'h40,       1, 32'h44,       2, 1);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h44,       0, 32'h40,       0, 32'h44,       2, 2);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'h48,       1, 32'h44,       0, 32'h48,       2, 2);
    // Flush with stall and MistakeD all asserted: flush wins, counters hold.
    vec(0, 0, 0, 0,             1, 32'h300,  0, 0, 0,       32'h4C,       1, 32'h48,       0, 32'h4C,       2, 2);
    vec(0, 1, 1, 32'hBFC00380,  0, 0,        0, 0, 0,       32'h300,      1, 32'h4C,       1, 32'h50,       2, 2);
    vec(0, 0, 0, 0,             0, 0,        0, 0, 0,       32'hBFC00380, 0, 32'h4C,       0, 32'h50,       2, 2);
    // Not-taken branches every cycle drive branch_cnt into saturation at 15.
    for (int k = 0; k < 16; k++) begin
      vec(0, 0, 0, 0, 0, 0, 1, 0, 0,
          32'hBFC00384 + 32'(4 * k), 1, 32'hBFC00380 + 32'(4 * k), 0, 32'hBFC00384 + 32'(4 * k),
          (2 + k > 15) ? 15 : 2 + k, 2);
    end
    // Reset asserted during a stall restores reset values immediately.
    vec(1, 1, 0, 0,             0, 0,        0, 0, 0,       32'hBFC00000, 0, 32'h0,        0, 32'h4,        0, 0);
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
